// File: rtl/instruction_fetch_buffer_if.sv
// Fetch-to-decode handshake bundle for instruction_fetch_buffer.
// The slave modport is the buffer; the master modport is the fetch/decode environment.
interface instruction_fetch_buffer_if #(
    parameter int unsigned PC_W = 32
);
    logic            fetch_valid;
    logic            fetch_ready;
    logic [PC_W-1:0] fetch_pc;
    logic [31:0]     fetch_instruction;
    logic            fetch_fault;
    logic            decode_valid;
    logic            decode_ready;
    logic [PC_W-1:0] decode_pc;
    logic [31:0]     decode_instruction;
    logic            decode_fault;

    modport slave (
        input  fetch_valid, fetch_pc, fetch_instruction, fetch_fault, decode_ready,
        output fetch_ready, decode_valid, decode_pc, decode_instruction, decode_fault
    );

    modport master (
        output fetch_valid, fetch_pc, fetch_instruction, fetch_fault, decode_ready,
        input  fetch_ready, decode_valid, decode_pc, decode_instruction, decode_fault
    );
endinterface

// File: rtl/instruction_fetch_buffer.sv
// FIFO of {pc, instruction, fault} between fetch and decode, with single-cycle flush.
// Optional INSTR_BUF_BYPASS_EN lets an empty buffer forward fetch straight to decode.
module instruction_fetch_buffer #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned PC_W  = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    instruction_fetch_buffer_if.slave bus,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;
    localparam int unsigned EW = PC_W + 33;

    logic [EW-1:0] mem_q [DEPTH];
    logic [PW-1:0] wptr_q, wptr_d;
    logic [PW-1:0] rptr_q, rptr_d;
    logic          empty, full, push, pop;
    logic [EW-1:0] head;

    // Extra pointer MSB distinguishes full from empty when index bits match
    assign empty = (wptr_q == rptr_q);
    assign full  = (wptr_q[AW-1:0] == rptr_q[AW-1:0]) && (wptr_q[AW] != rptr_q[AW]);
    assign head  = mem_q[rptr_q[AW-1:0]];
    assign count = wptr_q - rptr_q;

    assign bus.fetch_ready = ~full;

`ifdef INSTR_BUF_BYPASS_EN
    logic bypass;
    assign bypass                 = empty & ~flush;
    assign bus.decode_valid       = bypass ? bus.fetch_valid : (~empty & ~flush);
    assign bus.decode_pc          = bypass ? bus.fetch_pc : head[PC_W-1:0];
    assign bus.decode_instruction = bypass ? bus.fetch_instruction : head[PC_W+31:PC_W];
    assign bus.decode_fault       = bypass ? bus.fetch_fault : head[EW-1];
    // A bypassed entry taken by decode is never written into storage
    assign push = bus.fetch_valid & ~full & ~flush & ~(bypass & bus.decode_ready);
    assign pop  = ~empty & ~flush & bus.decode_ready;
`else
    assign bus.decode_valid       = ~empty & ~flush;
    assign bus.decode_pc          = head[PC_W-1:0];
    assign bus.decode_instruction = head[PC_W+31:PC_W];
    assign bus.decode_fault       = head[EW-1];
    assign push = bus.fetch_valid & ~full & ~flush;
    assign pop  = bus.decode_valid & bus.decode_ready;
`endif

    // Pointer next-state; flush wins over push and pop
    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (flush) begin
            wptr_d = '0;
            rptr_d = '0;
        end else begin
            if (push) wptr_d = wptr_q + PW'(1);
            if (pop)  rptr_d = rptr_q + PW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
        end else if (push) begin
            mem_q[wptr_q[AW-1:0]] <= {bus.fetch_fault, bus.fetch_instruction, bus.fetch_pc};
        end
    end
endmodule
